uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmit byte path (speed_setting + my_uart_tx pair) among NUM_REQ requesters.
//  Rotating-priority grant per byte; a requester holds the grant until its frame ends (req_last).
//  Sequences each byte: accept from requester, pulse tx_start, track tx_busy to completion.
//  Sits between on-chip byte sources (loopback, status, debug) and the TX datapath on clk_25m.
// PARAMETERS
//  NUM_REQ       4     number of requesters, 2..8
//  BUSY_TIMEOUT  64    cycles to wait for tx_busy to rise after tx_start before flagging error
//  LOCK_TIMEOUT  65535 idle cycles a locked requester may stall mid-frame before lock is dropped
// PORTS
//  clk          in   1          system clock
//  rst          in   1          synchronous reset, active-high
//  req_valid    in   NUM_REQ    byte offered by requester i
//  req_data     in   8*NUM_REQ  byte of requester i at [8i+7:8i]
//  req_last     in   NUM_REQ    offered byte is last of frame (qualified by req_valid)
//  req_ready    out  NUM_REQ    byte of requester i accepted this cycle (one-hot or zero)
//  tx_data      out  8          byte to transmitter, stable from tx_start until tx_busy falls
//  tx_start     out  1          one-cycle start pulse to transmitter
//  tx_busy      in   1          transmitter busy (high for the whole character)
//  grant_id     out  clog2(NUM_REQ)  current/last granted requester
//  frame_active out  1          a frame lock is held
//  err_pulse    out  1          one-cycle pulse on busy or lock timeout
// BEHAVIOUR
//  Reset: state IDLE, rr_ptr=0, req_ready=0, tx_data=0, tx_start=0, grant_id=0, frame_active=0,
//   err_pulse=0, both timeout counters=0. Reset mid-byte abandons it; no tx_start after reset.
//  Only registered outputs except req_ready (combinational from state, grant_id, req_valid).
//  States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
//  IDLE: if tx_busy=0 and |req_valid: grant_id <= first i with req_valid, searching
//   rr_ptr, rr_ptr+1, ... mod NUM_REQ; -> ISSUE. Otherwise stay. If frame_active, no arbitration:
//   grant_id is held and IDLE -> ISSUE only when req_valid[grant_id]=1.
//  ISSUE: req_ready[grant_id]=req_valid[grant_id]. On handshake: tx_data<=byte, tx_start<=1 next cycle,
//   frame_active<=~req_last[grant_id], -> WAIT_BUSY. If req_valid[grant_id] drops: -> IDLE, no transfer.
//  WAIT_BUSY: count cycles; tx_busy=1 -> WAIT_DONE. Count reaches BUSY_TIMEOUT: err_pulse=1,
//   frame_active<=0, rr_ptr<=grant_id+1, -> IDLE (byte lost).
//  WAIT_DONE: on tx_busy=0: if frame_active -> IDLE (locked); else rr_ptr<=grant_id+1 (wrap
//   NUM_REQ-1 -> 0), -> IDLE.
//  Latency: valid in IDLE (tx idle) -> req_ready 1 cycle later -> tx_start the cycle after.
//  Lock timeout: while frame_active and in IDLE with req_valid[grant_id]=0, count; at LOCK_TIMEOUT
//   drop frame_active, err_pulse=1, rr_ptr<=grant_id+1. Counter clears on any handshake.
//  Simultaneous: req_valid and req_last both high on single-byte frame -> no lock taken.
//  tx_start is never reasserted while tx_busy=1; at most one byte in flight.
// TESTING
//  1. rst, then req_valid=4'b0001 data 8'h55 last=1 -> req_ready[0] 1 cycle, tx_start with tx_data=8'h55.
//  2. req_valid=4'b1111 all last=1, model busy 10 cycles -> grant order 0,1,2,3,0; rr_ptr wraps 3->0.
//  3. Req1 frame 8'hA1,A2,A3 (last on A3) with req0/req2 valid -> A1..A3 sent contiguously, then req2.
//  4. tx_busy tied 0 after tx_start -> err_pulse after BUSY_TIMEOUT=64 cycles, state IDLE, next req served.
//  5. Req2 locked after A1, then req_valid[2]=0 for LOCK_TIMEOUT -> err_pulse, frame_active=0, req3 granted.
//  6. rst asserted in WAIT_DONE -> all outputs 0 next cycle, grant restarts at requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: rotating-priority, frame-locking arbiter that feeds one UART TX byte path
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65535,
    localparam int GW = $clog2(NUM_REQ),
    localparam int BW = $clog2(BUSY_TIMEOUT + 1),
    localparam int LW = $clog2(LOCK_TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic [GW-1:0]        grant_id,
    output logic                 frame_active,
    output logic                 err_pulse
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
    state_t        state_q;
    logic [GW-1:0] rr_ptr_q, grant_id_q, pick_d, next_d;
    logic [BW-1:0] busy_cnt_q;
    logic [LW-1:0] lock_cnt_q;
    logic [7:0]    tx_data_q;
    logic          tx_start_q, frame_active_q, err_pulse_q, cur_valid;
    int            idx;
    // Descending scan so the requester closest to rr_ptr wins the last write.
    always_comb begin
        pick_d = rr_ptr_q;
        idx = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            idx = (idx >= NUM_REQ) ? idx - NUM_REQ : idx;
            pick_d = req_valid[idx] ? GW'(idx) : pick_d;
        end
    end
    assign cur_valid    = req_valid[grant_id_q];
    assign next_d       = (grant_id_q == GW'(NUM_REQ - 1)) ? '0 : grant_id_q + GW'(1);
    assign req_ready    = (state_q == ISSUE && cur_valid) ? NUM_REQ'(1) << grant_id_q : '0;
    assign tx_data      = tx_data_q;
    assign tx_start     = tx_start_q;
    assign grant_id     = grant_id_q;
    assign frame_active = frame_active_q;
    assign err_pulse    = err_pulse_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            rr_ptr_q       <= '0;
            grant_id_q     <= '0;
            tx_data_q      <= '0;
            tx_start_q     <= 1'b0;
            frame_active_q <= 1'b0;
            err_pulse_q    <= 1'b0;
            busy_cnt_q     <= '0;
            lock_cnt_q     <= '0;
        end else begin
            tx_start_q  <= 1'b0;
            err_pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (frame_active_q) begin
                        if (cur_valid && !tx_busy) begin
                            state_q <= ISSUE;
                        end else if (!cur_valid) begin
                            // A stalled lock holder is evicted so others are not starved.
                            if (lock_cnt_q == LW'(LOCK_TIMEOUT - 1)) begin
                                lock_cnt_q     <= '0;
                                frame_active_q <= 1'b0;
                                err_pulse_q    <= 1'b1;
                                rr_ptr_q       <= next_d;
                            end else begin
                                lock_cnt_q <= lock_cnt_q + LW'(1);
                            end
                        end
                    end else if (|req_valid && !tx_busy) begin
                        grant_id_q <= pick_d;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cur_valid) begin
                        tx_data_q      <= req_data[{grant_id_q, 3'b000} +: 8];
                        tx_start_q     <= 1'b1;
                        frame_active_q <= ~req_last[grant_id_q];
                        lock_cnt_q     <= '0;
                        busy_cnt_q     <= '0;
                        state_q        <= WAIT_BUSY;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (busy_cnt_q == BW'(BUSY_TIMEOUT - 1)) begin
                        err_pulse_q    <= 1'b1;
                        frame_active_q <= 1'b0;
                        rr_ptr_q       <= next_d;
                        state_q        <= IDLE;
                    end else begin
                        busy_cnt_q <= busy_cnt_q + BW'(1);
                    end
                end
                default: begin
                    if (!tx_busy) begin
                        rr_ptr_q <= frame_active_q ? rr_ptr_q : next_d;
                        state_q  <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios against a simple transmitter model and byte sources
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int BT = 64;
    localparam int LT = 100;
    localparam int BL = 10;
    logic           clk = 1'b0, rst = 1'b1;
    logic [N-1:0]   req_valid = '0, req_last = '0, req_ready;
    logic [8*N-1:0] req_data = '0;
    logic [7:0]     tx_data;
    logic           tx_start, tx_busy = 1'b0, frame_active, err_pulse;
    logic [1:0]     grant_id;
    int             errors = 0, checks = 0;
    int             cyc = 0, bcnt = 0, ignore_starts = 0, nerr = 0, err_cyc = 0, rdy_cycles = 0;
    int             log_gid[$], log_data[$], log_cyc[$];
    logic [7:0]     sd[N][8];
    logic           sl[N][8];
    int             slen[N], spos[N];

    uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(BT), .LOCK_TIMEOUT(LT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .grant_id(grant_id), .frame_active(frame_active), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy for BL cycles from the tx_start cycle; also logs events.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            bcnt = 0;
            tx_busy = 1'b0;
        end else begin
            if (err_pulse) begin
                nerr++;
                err_cyc = cyc;
            end
            if (|req_ready) rdy_cycles++;
            if (tx_start) begin
                checks++;
                if (tx_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL start_while_busy tx_busy=%b exp=0", tx_busy);
                end
                log_gid.push_back(int'(grant_id));
                log_data.push_back(int'(tx_data));
                log_cyc.push_back(cyc);
                if (ignore_starts > 0) ignore_starts--;
                else begin
                    tx_busy = 1'b1;
                    bcnt = BL;
                end
            end else if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) tx_busy = 1'b0;
            end
        end
    end

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = spos[i] < slen[i];
            req_data[8*i +: 8] = req_valid[i] ? sd[i][spos[i]] : 8'h00;
            req_last[i] = req_valid[i] && sl[i][spos[i]];
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < N; i++) begin
            slen[i] = 0;
            spos[i] = 0;
        end
    endtask

    task automatic add_byte(input int i, input logic [7:0] d, input logic l);
        sd[i][slen[i]] = d;
        sl[i][slen[i]] = l;
        slen[i]++;
    endtask

    task automatic step();
        logic [N-1:0] hs;
        @(negedge clk);
        hs = req_ready & req_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (hs[i]) spos[i]++;
        drive();
    endtask

    task automatic wait_starts(input int n, input int max, output bit ok);
        for (int k = 0; k < max && log_gid.size() < n; k++) step();
        ok = log_gid.size() >= n;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_src();
        drive();
        ignore_starts = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        log_gid.delete();
        log_data.delete();
        log_cyc.delete();
        nerr = 0;
        rdy_cycles = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({req_ready, tx_data, tx_start, grant_id, frame_active, err_pulse} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {req_ready, tx_data, tx_start, grant_id, frame_active, err_pulse});
        end
    endtask

    task automatic test_single();
        do_reset();
        add_byte(0, 8'h55, 1'b1);
        drive();
        step();
        checks++;
        if (req_ready !== 4'b0001 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL single_ready got=%b/%b exp=0001/0", req_ready, tx_start);
        end
        step();
        checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h55 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL single_start got=%b/%h/%b exp=1/55/0000", tx_start, tx_data, req_ready);
        end
        repeat (15) step();
        checks++;
        if (rdy_cycles != 1 || frame_active !== 1'b0 || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL single_tail got=%0d/%b/%0d exp=1/0/0", rdy_cycles, frame_active, grant_id);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int eg, ed;
        do_reset();
        for (int i = 0; i < N; i++) begin
            add_byte(i, 8'hC0 + 8'(i), 1'b1);
            add_byte(i, 8'hD0 + 8'(i), 1'b1);
        end
        drive();
        wait_starts(8, 200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rr_timeout starts=%0d exp=8", log_gid.size());
        end
        for (int k = 0; k < 8; k++) begin
            eg = k % 4;
            ed = (k < 4 ? 'hC0 : 'hD0) + k % 4;
            checks++;
            if ((k < log_gid.size() ? log_gid[k] : -1) != eg || (k < log_data.size() ? log_data[k] : -1) != ed) begin
                errors++;
                $display("FAIL rr_order[%0d] got=%0d/%h exp=%0d/%h", k,
                         k < log_gid.size() ? log_gid[k] : -1, k < log_data.size() ? log_data[k] : -1, eg, ed);
            end
        end
    endtask

    task automatic test_frame_lock();
        bit ok;
        int eg[5] = '{0, 1, 1, 1, 2};
        int ed[5] = '{'h0F, 'hA1, 'hA2, 'hA3, 'hB2};
        do_reset();
        add_byte(0, 8'h0F, 1'b1);
        drive();
        wait_starts(1, 50, ok);
        add_byte(1, 8'hA1, 1'b0);
        add_byte(1, 8'hA2, 1'b0);
        add_byte(1, 8'hA3, 1'b1);
        add_byte(0, 8'h01, 1'b1);
        add_byte(2, 8'hB2, 1'b1);
        drive();
        wait_starts(5, 200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL frame_timeout starts=%0d exp=5", log_gid.size());
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ((k < log_gid.size() ? log_gid[k] : -1) != eg[k] || (k < log_data.size() ? log_data[k] : -1) != ed[k]) begin
                errors++;
                $display("FAIL frame_order[%0d] got=%0d/%h exp=%0d/%h", k,
                         k < log_gid.size() ? log_gid[k] : -1, k < log_data.size() ? log_data[k] : -1, eg[k], ed[k]);
            end
        end
        repeat (14) step();
        checks++;
        if (frame_active !== 1'b0) begin
            errors++;
            $display("FAIL frame_release got=%b exp=0", frame_active);
        end
    endtask

    task automatic test_busy_timeout();
        bit ok;
        do_reset();
        ignore_starts = 1;
        add_byte(0, 8'h44, 1'b1);
        add_byte(1, 8'h45, 1'b1);
        drive();
        wait_starts(2, 150, ok);
        checks++;
        if (!ok || log_gid[0] != 0 || log_gid[1] != 1 || log_data[1] != 'h45) begin
            errors++;
            $display("FAIL busy_to_next got=%0d starts exp=2 (0:44,1:45)", log_gid.size());
        end
        checks++;
        if (nerr != 1 || err_cyc - log_cyc[0] != BT) begin
            errors++;
            $display("FAIL busy_to_err got=%0d errs after %0d cycles exp=1 after %0d", nerr, err_cyc - log_cyc[0], BT);
        end
        checks++;
        if (ok && log_cyc[1] - err_cyc != 2) begin
            errors++;
            $display("FAIL busy_to_idle got=%0d exp=2", log_cyc[1] - err_cyc);
        end
        repeat (14) step();
    endtask

    task automatic test_lock_timeout();
        bit ok;
        do_reset();
        add_byte(2, 8'hA1, 1'b0);
        add_byte(3, 8'h33, 1'b1);
        drive();
        wait_starts(1, 50, ok);
        repeat (20) step();
        checks++;
        if (frame_active !== 1'b1 || grant_id !== 2'd2 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL lock_held got=%b/%0d/%b exp=1/2/0000", frame_active, grant_id, req_ready);
        end
        wait_starts(2, 300, ok);
        checks++;
        if (!ok || log_gid[0] != 2 || log_gid[1] != 3 || log_data[1] != 'h33) begin
            errors++;
            $display("FAIL lock_next got=%0d starts exp=2 (2:A1,3:33)", log_gid.size());
        end
        checks++;
        if (nerr != 1 || err_cyc - log_cyc[0] != LT + BL + 1) begin
            errors++;
            $display("FAIL lock_err got=%0d errs after %0d exp=1 after %0d", nerr, err_cyc - log_cyc[0], LT + BL + 1);
        end
        repeat (14) step();
        checks++;
        if (frame_active !== 1'b0) begin
            errors++;
            $display("FAIL lock_release got=%b exp=0", frame_active);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        add_byte(0, 8'h01, 1'b1);
        drive();
        wait_starts(1, 50, ok);
        add_byte(1, 8'h62, 1'b1);
        drive();
        wait_starts(2, 100, ok);
        rst = 1'b1;
        clear_src();
        add_byte(0, 8'h70, 1'b1);
        add_byte(1, 8'h71, 1'b1);
        drive();
        log_gid.delete();
        log_data.delete();
        log_cyc.delete();
        @(posedge clk);
        #1;
        checks++;
        if ({req_ready, tx_data, tx_start, grant_id, frame_active, err_pulse} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got=%h exp=0",
                     {req_ready, tx_data, tx_start, grant_id, frame_active, err_pulse});
        end
        rst = 1'b0;
        wait_starts(2, 100, ok);
        checks++;
        if (!ok || log_gid[0] != 0 || log_data[0] != 'h70 || log_gid[1] != 1 || log_data[1] != 'h71) begin
            errors++;
            $display("FAIL mid_reset_restart got=%0d starts first=%0d exp=2 first=0",
                     log_gid.size(), log_gid.size() > 0 ? log_gid[0] : -1);
        end
        repeat (14) step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_frame_lock();
        test_busy_timeout();
        test_lock_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
